// File: rtl/idct_1d_seq.sv
// -----------------------------------------------------------------------------
// idct_1d_seq : 8-point 1D inverse DCT-II, time-multiplexed.
//
// One output pair y[k] / y[7-k] is produced per clock over four clocks using
// the even/odd partial-butterfly decomposition with the integer basis
// (64, 83, 36, 89, 75, 50, 18). The odd part shares four constant multipliers
// whose constants are selected by the pair index k.
//
// Configuration macro: IDCT_CLIP_EN
//   defined   : each shifted result saturates to [-32768, 32767]
//   undefined : the low 16 bits of each shifted result are taken (wrap)
// -----------------------------------------------------------------------------
module idct_1d_seq #(
    parameter int SHIFT = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [26:0] RND = 27'sd1 <<< (SHIFT - 1);

    // Signed 16-bit coefficient times a small signed constant, 23-bit product.
    function automatic logic signed [22:0] mul_c(input logic signed [15:0] x,
                                                 input logic signed [7:0]  m);
        logic signed [22:0] xe;
        logic signed [22:0] me;
        xe = {{7{x[15]}}, x};
        me = {{15{m[7]}}, m};
        return xe * me;
    endfunction

    // Range control of one shifted 27-bit result down to a 16-bit sample.
    function automatic logic [15:0] range_ctl(input logic signed [26:0] v);
`ifdef IDCT_CLIP_EN
        if (v > 27'sd32767) begin
            return 16'h7fff;
        end else if (v < -27'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
`else
        return v[15:0];
`endif
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [127:0]        coef_r;
    logic [1:0]          k_r;
    logic [127:0]        out_data_r;
    logic                out_valid_r;

    logic                in_ready_s;
    logic                accept_s;
    logic signed [15:0]  c_s [8];

    logic signed [24:0]  ee0_s;
    logic signed [24:0]  ee1_s;
    logic signed [24:0]  eo0_s;
    logic signed [24:0]  eo1_s;
    logic signed [26:0]  e_k_s;

    logic signed [7:0]   m1_s;
    logic signed [7:0]   m3_s;
    logic signed [7:0]   m5_s;
    logic signed [7:0]   m7_s;
    logic signed [24:0]  o_sum_s;
    logic signed [26:0]  o_k_s;

    logic signed [26:0]  sum_s;
    logic signed [26:0]  dif_s;
    logic signed [26:0]  sum_sh_s;
    logic signed [26:0]  dif_sh_s;
    logic [15:0]         y_lo_s;
    logic [15:0]         y_hi_s;
    logic [2:0]          hi_pos_s;
    logic [6:0]          lo_idx_s;
    logic [6:0]          hi_idx_s;

    assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign accept_s   = in_valid & in_ready_s;
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;

    // Unpack the latched coefficient vector into signed lanes.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            c_s[i] = coef_r[16*i +: 16];
        end
    end

    // Even part: full butterfly, then pick E[k] for the current pair.
    always_comb begin
        ee0_s = 25'(mul_c(c_s[0], 8'sd64)) + 25'(mul_c(c_s[4], 8'sd64));
        ee1_s = 25'(mul_c(c_s[0], 8'sd64)) - 25'(mul_c(c_s[4], 8'sd64));
        eo0_s = 25'(mul_c(c_s[2], 8'sd83)) + 25'(mul_c(c_s[6], 8'sd36));
        eo1_s = 25'(mul_c(c_s[2], 8'sd36)) - 25'(mul_c(c_s[6], 8'sd83));
        e_k_s = 27'sd0;
        case (k_r)
            2'd0:    e_k_s = 27'(ee0_s) + 27'(eo0_s);
            2'd1:    e_k_s = 27'(ee1_s) + 27'(eo1_s);
            2'd2:    e_k_s = 27'(ee1_s) - 27'(eo1_s);
            2'd3:    e_k_s = 27'(ee0_s) - 27'(eo0_s);
            default: e_k_s = 27'sd0;
        endcase
    end

    // Odd part: one row of the odd basis per pair, four shared multipliers.
    always_comb begin
        m1_s = 8'sd0;
        m3_s = 8'sd0;
        m5_s = 8'sd0;
        m7_s = 8'sd0;
        case (k_r)
            2'd0: begin m1_s = 8'sd89; m3_s =  8'sd75; m5_s =  8'sd50; m7_s =  8'sd18; end
            2'd1: begin m1_s = 8'sd75; m3_s = -8'sd18; m5_s = -8'sd89; m7_s = -8'sd50; end
            2'd2: begin m1_s = 8'sd50; m3_s = -8'sd89; m5_s =  8'sd18; m7_s =  8'sd75; end
            2'd3: begin m1_s = 8'sd18; m3_s = -8'sd50; m5_s =  8'sd75; m7_s = -8'sd89; end
            default: begin m1_s = 8'sd0; m3_s = 8'sd0; m5_s = 8'sd0; m7_s = 8'sd0; end
        endcase
        o_sum_s = 25'(mul_c(c_s[1], m1_s)) + 25'(mul_c(c_s[3], m3_s))
                + 25'(mul_c(c_s[5], m5_s)) + 25'(mul_c(c_s[7], m7_s));
        o_k_s   = 27'(o_sum_s);
    end

    // Output pair: round, arithmetic shift, range control, lane positions.
    always_comb begin
        sum_s    = e_k_s + o_k_s + RND;
        dif_s    = e_k_s - o_k_s + RND;
        sum_sh_s = sum_s >>> SHIFT;
        dif_sh_s = dif_s >>> SHIFT;
        y_lo_s   = range_ctl(sum_sh_s);
        y_hi_s   = range_ctl(dif_sh_s);
        hi_pos_s = 3'd7 - {1'b0, k_r};
        lo_idx_s = {1'b0, k_r, 4'b0000};
        hi_idx_s = {hi_pos_s, 4'b0000};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (k_r == 2'd3) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CALC;
                end
            end
            DONE: begin
                if (accept_s) begin
                    next_state_s = CALC;
                end else if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath registers: latch on accept, write one pair per CALC clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_r      <= '0;
            k_r         <= 2'd0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                coef_r <= in_data;
                k_r    <= 2'd0;
            end
            case (state_r)
                CALC: begin
                    out_data_r[lo_idx_s +: 16] <= y_lo_s;
                    out_data_r[hi_idx_s +: 16] <= y_hi_s;
                    k_r <= k_r + 2'd1;
                    if (k_r == 2'd3) begin
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct_1d_seq.sv
// -----------------------------------------------------------------------------
// tb_idct_1d_seq : self-checking bench for idct_1d_seq.
// A negedge monitor pushes golden results on every accept and pops/compares
// them on every output handshake; directed checks cover the listed corners.
// Honours IDCT_CLIP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_idct_1d_seq;

    localparam int SHIFT = 7;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [127:0] sb_q [$];

    idct_1d_seq #(.SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
`ifdef IDCT_CLIP_EN
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    // Golden model straight from the butterfly equations.
    function automatic logic [127:0] idct_model(input logic [127:0] d);
        int c [8];
        int e [4];
        int o [4];
        int ee0, ee1, eo0, eo1, rnd, a, b;
        logic [127:0] r;
        for (int i = 0; i < 8; i++) c[i] = int'($signed(d[16*i +: 16]));
        ee0 = 64*c[0] + 64*c[4];
        ee1 = 64*c[0] - 64*c[4];
        eo0 = 83*c[2] + 36*c[6];
        eo1 = 36*c[2] - 83*c[6];
        e[0] = ee0 + eo0; e[3] = ee0 - eo0;
        e[1] = ee1 + eo1; e[2] = ee1 - eo1;
        o[0] = 89*c[1] + 75*c[3] + 50*c[5] + 18*c[7];
        o[1] = 75*c[1] - 18*c[3] - 89*c[5] - 50*c[7];
        o[2] = 50*c[1] - 89*c[3] + 18*c[5] + 75*c[7];
        o[3] = 18*c[1] - 50*c[3] + 75*c[5] - 89*c[7];
        rnd = 1 << (SHIFT - 1);
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a = (e[k] + o[k] + rnd) >>> SHIFT;
            b = (e[k] - o[k] + rnd) >>> SHIFT;
            r[16*k +: 16]     = sat16(a);
            r[16*(7-k) +: 16] = sat16(b);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_vec();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = 16'($urandom);
        return v;
    endfunction

    // Scoreboard: pop/compare on output handshake, push golden on accept.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 128'd1, 128'd0);
            end else begin
                check_eq("sb_data", out_data, sb_q.pop_front());
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back(idct_model(in_data));
        end
    end

    // Present a vector until accepted; returns at accept edge + 1.
    task automatic send(input logic [127:0] v);
        bit ok;
        ok = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("send_accept", 128'(ok), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; returns on a negedge.
    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("wait_valid", 128'(ok), 128'd1);
    endtask

    logic [127:0] v, v2, exp;
    logic [127:0] vv [3];
    int lat, got, idx;
    int t [3];
    bit acc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #22;
        check_eq("rst_in_ready",  128'(in_ready),  128'd1);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_out_data",  out_data,        128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DC vector and latency.
        v = '0;
        v[15:0] = 16'sd64;
        send(v);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check_eq("dc_latency", 128'(lat), 128'd4);
        check_eq("dc_data", out_data, {8{16'd32}});
        @(posedge clk);
        #1;

        // Single odd coefficient.
        v = '0;
        v[31:16] = 16'sd64;
        send(v);
        wait_valid();
        exp = {-16'sd44, -16'sd37, -16'sd25, -16'sd9, 16'sd9, 16'sd25, 16'sd38, 16'sd45};
        check_eq("c1_data", out_data, exp);
        @(posedge clk);
        #1;

        // Range control on a large even vector.
        v = '0;
        v[15:0]  = 16'sd32767;
        v[47:32] = 16'sd32767;
        v[79:64] = 16'sd32767;
        send(v);
        wait_valid();
`ifdef IDCT_CLIP_EN
        check_eq("clip_y0", 128'(out_data[15:0]), 128'(16'sd32767));
`else
        check_eq("wrap_y0", 128'(out_data[15:0]), 128'(16'hd2fe));
`endif
        @(posedge clk);
        #1;

        // Backpressure: result must hold for 10 cycles.
        out_ready = 1'b0;
        v = rand_vec();
        send(v);
        wait_valid();
        exp = idct_model(v);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid", 128'(out_valid), 128'd1);
            check_eq("bp_data",  out_data,        exp);
            check_eq("bp_ready", 128'(in_ready),  128'd0);
            @(negedge clk);
        end
        // Release and present a new vector in the same cycle.
        @(posedge clk);
        #1;
        v2 = rand_vec();
        in_data   = v2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("swap_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("swap_out_valid", 128'(out_valid), 128'd0);
        check_eq("swap_busy",      128'(in_ready),  128'd0);
        wait_valid();
        check_eq("swap_data", out_data, idct_model(v2));
        @(posedge clk);
        #1;

        // Back-to-back stream of three vectors.
        for (int i = 0; i < 3; i++) vv[i] = rand_vec();
        got = 0;
        idx = 0;
        in_data  = vv[0];
        in_valid = 1'b1;
        for (int i = 0; i < 60 && got < 3; i++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            if (out_valid) begin
                t[got] = cyc;
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    in_data = vv[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check_eq("b2b_count", 128'(got), 128'd3);
        if (got == 3) begin
            check_eq("b2b_gap0", 128'(t[1] - t[0]), 128'd5);
            check_eq("b2b_gap1", 128'(t[2] - t[1]), 128'd5);
        end

        // Reset during CALC with k == 2.
        v = rand_vec();
        send(v);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("mid_rst_out_data",  out_data,        128'd0);
        check_eq("mid_rst_in_ready",  128'(in_ready),  128'd1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        v = rand_vec();
        send(v);
        wait_valid();
        check_eq("post_rst_data", out_data, idct_model(v));
        @(posedge clk);
        #1;

        // Drain the scoreboard.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("sb_drain", 128'(sb_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idct_1d_seq.md
Name: idct_1d_seq

Overview:
- 8-point 1D inverse DCT-II, the decoder-side counterpart of the team's forward 8-point DCT.
- Uses the same integer basis (64, 83, 36, 89, 75, 50, 18) and the even/odd partial-butterfly structure.
- Time-multiplexed: computes one output pair y[k]/y[7-k] per clock over 4 clocks, with rounding shift and range control.
- Sits between the coefficient dequantiser and the column/row transpose buffer of the inverse 2D path. Valid/ready handshake on both sides.

Parameters:
SHIFT, 7, right shift applied after the butterfly (7 for the first inverse stage, 12 for the second); rounding offset is 1<<(SHIFT-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  coefficient vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_data  in  128  8 signed 16-bit coefficients; c[i] = in_data[16*i+15:16*i], c[0] = DC.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  128  8 signed 16-bit samples; y[i] = out_data[16*i+15:16*i].

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, k=0, internal coefficient register=0.
- Reset mid-operation: aborts the vector in flight with no partial output. First acceptance is possible on the first clk edge after rst_n deasserts.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept occurs when in_valid & in_ready at a rising edge.
- IDLE -> CALC on accept: latch in_data, k<=0.
- CALC, each clock computes pair k and writes y[k] and y[7-k] into the out_data register; k increments. At k==3 -> DONE, out_valid<=1.
- DONE: hold out_valid and out_data stable until out_ready.
  - out_ready & accept in the same cycle: -> CALC, new vector latched.
  - out_ready without in_valid: -> IDLE, out_valid<=0.
- Latency: out_valid is high in the 4th cycle after the accept edge.
- Throughput: one vector per 5 cycles with out_ready held high.
- Even part:
  - Ee0 = 64*c0 + 64*c4; Ee1 = 64*c0 - 64*c4.
  - Eo0 = 83*c2 + 36*c6; Eo1 = 36*c2 - 83*c6.
  - E0 = Ee0 + Eo0; E3 = Ee0 - Eo0; E1 = Ee1 + Eo1; E2 = Ee1 - Eo1.
- Odd part:
  - O0 = 89c1 + 75c3 + 50c5 + 18c7.
  - O1 = 75c1 - 18c3 - 89c5 - 50c7.
  - O2 = 50c1 - 89c3 + 18c5 + 75c7.
  - O3 = 18c1 - 50c3 + 75c5 - 89c7.
- Outputs: y[k] = (E[k] + O[k] + rnd) >>> SHIFT; y[7-k] = (E[k] - O[k] + rnd) >>> SHIFT. Arithmetic shift, floor toward -inf.
- Widths: products 23 bits signed; 4-term sums 25 bits; E±O computed at 27 bits signed with no internal overflow for any 16-bit input.
- Multipliers: constant multiplies may be shift-add or '*'; results must be bit-exact to the formulas above.
- in_data changes while not accepted have no effect. out_data changes only at CALC writes, never while out_valid=1.

Optional Feature:
- Macro: IDCT_CLIP_EN.
- Defined: each 27-bit shifted result saturates to [-32768, 32767].
- Undefined: the low 16 bits are taken (two's-complement wrap). Saves comparator logic when the upstream range is guaranteed.

Test Plan:
- DC: SHIFT=7, c0=64, others 0 -> y[0..7] all 32; out_valid rises 4 cycles after accept.
- c1=64, others 0 -> y = {45, 38, 25, 9, -9, -25, -37, -44}.
- c0=c2=c4=32767, others 0 -> y[0]=32767 with IDCT_CLIP_EN; y[0]=-11522 without it.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_data stable, in_ready=0.
- Then out_ready=1 with in_valid=1 in the same cycle -> new vector accepted on that edge.
- Back-to-back: 3 vectors, in_valid and out_ready held 1 -> 3 results at 5-cycle spacing, matching a golden model.
- Reset mid-op: assert rst_n=0 during CALC k=2 -> out_valid=0, out_data=0, in_ready=1 immediately; vector after release produces the correct result.
